// File: rtl/neuron_mac_16_bit_pkg.sv
// rtl/neuron_mac_16_bit_pkg.sv - shared fixed-point constants and FSM encoding
package neuron_mac_16_bit_pkg;

  localparam int N = 16;
  localparam int Q = 12;

  localparam logic [15:0] SAT_MAX = 16'h7FFF;
  localparam logic [15:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/neuron_mac_16_bit_fx_shift_saturate.sv
// rtl/neuron_mac_16_bit_fx_shift_saturate.sv - arithmetic right shift then clamp to a signed N-bit word
module fx_shift_saturate #(
  parameter int IN_W  = 40,
  parameter int OUT_W = 16,
  parameter int SHIFT = 12
) (
  input  logic [IN_W-1:0]  din_i,
  output logic [OUT_W-1:0] dout_o
);

  localparam logic signed [IN_W-1:0] MAX_EXT = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_EXT = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] shifted;

  // >>> on a signed operand floors toward -inf, matching fixed-point truncation.
  assign shifted = $signed(din_i) >>> SHIFT;

  always_comb begin
    dout_o = shifted[OUT_W-1:0];
    if (shifted > MAX_EXT) begin
      dout_o = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (shifted < MIN_EXT) begin
      dout_o = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

endmodule

// File: rtl/neuron_mac_16_bit.sv
// rtl/neuron_mac_16_bit.sv - K-input multiply-accumulate neuron with biased, saturated Q-format output
module neuron_mac_16_bit
  import neuron_mac_16_bit_pkg::*;
#(
  parameter int N     = neuron_mac_16_bit_pkg::N,
  parameter int Q     = neuron_mac_16_bit_pkg::Q,
  parameter int K     = 8,
  parameter int ACC_W = 2*N+8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] bias,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x_in,
  input  logic [N-1:0] w_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic         busy
);

  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [N-1:0]       y_q;
  logic [N-1:0]       y_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic signed [2*N-1:0] prod;
  logic [ACC_W-1:0]      prod_ext;
  logic [ACC_W-1:0]      bias_ext;
  logic                  beat;
  logic                  last_beat;

  assign prod      = $signed(x_in) * $signed(w_in);
  assign prod_ext  = {{(ACC_W-2*N){prod[2*N-1]}}, prod};
  assign bias_ext  = {{(ACC_W-N){bias[N-1]}}, bias} << Q;
  assign acc_d     = acc_q + prod_ext;
  assign beat      = in_valid && in_ready_q;
  assign last_beat = beat && (cnt_q == CNT_W'(K-1));

  // y is taken from the sum that includes the final beat, so it is ready as out_valid rises.
  fx_shift_saturate #(
    .IN_W  (ACC_W),
    .OUT_W (N),
    .SHIFT (Q)
  ) u_sat (
    .din_i  (acc_d),
    .dout_o (y_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      y_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc_q      <= bias_ext;
            cnt_q      <= '0;
            state_q    <= ST_ACC;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_ACC: begin
          if (beat) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) begin
              state_q     <= ST_OUT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              y_q         <= y_d;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_neuron_mac_16_bit.sv
// tb/tb_neuron_mac_16_bit.sv - scoreboard bench for neuron_mac_16_bit at K=4 and K=8
module tb_neuron_mac_16_bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start8;
  logic        in_valid, out_ready;
  logic [15:0] bias, x_in, w_in;
  logic        rdy4, ov4, busy4, rdy8, ov8, busy8;
  logic [15:0] y4, y8;

  always #5 clk = ~clk;

  neuron_mac_16_bit #(.K(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .bias(bias),
    .in_valid(in_valid), .in_ready(rdy4), .x_in(x_in), .w_in(w_in),
    .out_valid(ov4), .out_ready(out_ready), .y(y4), .busy(busy4)
  );

  neuron_mac_16_bit #(.K(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .bias(bias),
    .in_valid(in_valid), .in_ready(rdy8), .x_in(x_in), .w_in(w_in),
    .out_valid(ov8), .out_ready(out_ready), .y(y8), .busy(busy8)
  );

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] xs[8];
  logic [15:0] ws[8];
  bit          use8 = 1'b0;
  logic        sel_ov, sel_rdy, sel_busy;
  logic [15:0] sel_y;

  always_comb begin
    sel_ov   = use8 ? ov8   : ov4;
    sel_rdy  = use8 ? rdy8  : rdy4;
    sel_busy = use8 ? busy8 : busy4;
    sel_y    = use8 ? y8    : y4;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_y(input longint s);
    longint t;
    t = s >>> 12;
    if (t > 32767) return 16'h7FFF;
    if (t < -32768) return 16'h8000;
    return t[15:0];
  endfunction

  task automatic set_beats(input logic [15:0] x, input logic [15:0] w);
    for (int i = 0; i < 8; i++) begin
      xs[i] = x;
      ws[i] = w;
    end
  endtask

  task automatic run(input bit sel8, input logic [15:0] b, input bit gaps, input int hold);
    int          k;
    int          waited;
    longint      s;
    logic [15:0] exp;
    k    = sel8 ? 8 : 4;
    use8 = sel8;
    s = longint'($signed(b)) <<< 12;
    for (int i = 0; i < k; i++) s += longint'($signed(xs[i])) * longint'($signed(ws[i]));
    exp_q.push_back(model_y(s));

    bias = b;
    if (sel8) start8 = 1'b1; else start4 = 1'b1;
    step();
    start4 = 1'b0;
    start8 = 1'b0;
    bias   = 16'($urandom);
    check("in_ready_acc", 32'(sel_rdy), 32'd1);
    check("busy_acc", 32'(sel_busy), 32'd1);

    for (int i = 0; i < k; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          x_in     = 16'($urandom);
          step();
        end
      end
      in_valid = 1'b1;
      x_in     = xs[i];
      w_in     = ws[i];
      step();
    end
    in_valid = 1'b0;
    check("out_valid_latency", 32'(sel_ov), 32'd1);
    waited = 0;
    while (!sel_ov && waited < 20) begin
      step();
      waited++;
    end
    check("out_valid_wait", 32'(sel_ov), 32'd1);
    exp = exp_q.pop_front();
    check("y", 32'(sel_y), 32'(exp));
    check("in_ready_out", 32'(sel_rdy), 32'd0);

    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin
        if (sel8) start8 = 1'b1; else start4 = 1'b1;
        in_valid = 1'b1;
      end
      step();
      start4   = 1'b0;
      start8   = 1'b0;
      in_valid = 1'b0;
      check("hold_y", 32'(sel_y), 32'(exp));
      check("hold_out_valid", 32'(sel_ov), 32'd1);
      check("hold_in_ready", 32'(sel_rdy), 32'd0);
    end

    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_drop", 32'(sel_ov), 32'd0);
    check("busy_idle", 32'(sel_busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    start4    = 1'b0;
    start8    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bias      = 16'h0;
    x_in      = 16'h0;
    w_in      = 16'h0;
    repeat (2) step();
    check("rst_out_valid4", 32'(ov4), 32'd0);
    check("rst_in_ready4", 32'(rdy4), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_y4", 32'(y4), 32'd0);
    check("rst_out_valid8", 32'(ov8), 32'd0);
    check("rst_y8", 32'(y8), 32'd0);
    rst = 1'b1;
    step();

    set_beats(16'h1000, 16'h0800); run(1'b0, 16'h0000, 1'b0, 0);
    set_beats(16'h7000, 16'h7000); run(1'b0, 16'h0800, 1'b0, 0);
    set_beats(16'h9000, 16'h7000); run(1'b0, 16'h0800, 1'b0, 0);
    set_beats(16'hFFFF, 16'h0001); run(1'b0, 16'h0000, 1'b0, 0);
    set_beats(16'h0001, 16'h0001); run(1'b0, 16'h0000, 1'b0, 0);
    set_beats(16'h1000, 16'h0800); run(1'b0, 16'h0000, 1'b0, 5);

    // Abort a run mid-way; the follow-up run must show no trace of it.
    use8   = 1'b0;
    bias   = 16'h1234;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      x_in     = 16'h7FFF;
      w_in     = 16'h7FFF;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    check("abort_out_valid", 32'(ov4), 32'd0);
    check("abort_in_ready", 32'(rdy4), 32'd0);
    check("abort_busy", 32'(busy4), 32'd0);
    check("abort_y", 32'(y4), 32'd0);
    rst = 1'b1;
    step();
    set_beats(16'h1000, 16'h1000); run(1'b0, 16'h0000, 1'b0, 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) begin
        xs[i] = 16'($urandom);
        ws[i] = 16'($urandom);
        if (r % 2 == 1) begin
          xs[i] = {{6{xs[i][9]}}, xs[i][9:0]};
          ws[i] = {{4{ws[i][11]}}, ws[i][11:0]};
        end
      end
      run(1'b1, 16'($urandom), 1'b1, $urandom_range(0, 3));
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neuron_mac_16_bit.md
NEURON_MAC_16_BIT -- requirements
Module: neuron_mac_16_bit

Interface
REQ-001 Parameter N, default 16: data word width, two's complement fixed point.
REQ-002 Parameter Q, default 12: fractional bits (Q4.12 at defaults).
REQ-003 Parameter K, default 8: inputs per neuron; legal range 1..256.
REQ-004 Parameter ACC_W, default 2*N+8: accumulator width.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  begin a new neuron when in IDLE.
REQ-008 bias  input  N  Q-format bias, sampled on the accepted start.
REQ-009 in_valid  input  1  x_in/w_in beat valid.
REQ-010 in_ready  output  1  block accepts a beat.
REQ-011 x_in  input  N  activation operand.
REQ-012 w_in  input  N  weight operand.
REQ-013 out_valid  output  1  y holds the finished pre-activation.
REQ-014 out_ready  input  1  downstream (softplus stage) consumes y.
REQ-015 y  output  N  saturated Q-format pre-activation, feeds the softplus input.
REQ-016 busy  output  1  high in ACC or OUT.

Function
REQ-017 The FSM has three states: IDLE, ACC and OUT.
REQ-018 IDLE: in_ready=0 and out_valid=0; when start=1, load acc = sign-extended bias << Q, load cnt=0, and go to ACC on the next edge.
REQ-019 ACC: in_ready=1; a beat transfers on in_valid&&in_ready; each transfer adds the full-precision 2N-bit signed product x_in*w_in, sign-extended to ACC_W, into acc in the same edge.
REQ-020 ACC: cnt increments per transfer; the transfer with cnt==K-1 moves the FSM to OUT, and no further beats are accepted in that cycle or after it.
REQ-021 OUT: out_valid=1 and in_ready=0; y = sat(acc >>> Q), an arithmetic right shift (truncation toward -inf).
REQ-022 The saturation clamps to 0x7FFF when the value exceeds +max and to 0x8000 when it is below -min; otherwise it takes the low N bits.
REQ-023 The y register is computed on the transition into OUT and stays stable while out_valid=1 and out_ready=0.
REQ-024 OUT with out_ready=1: return to IDLE on the next edge; out_valid is 0 in that next cycle.
REQ-025 Latency: out_valid rises on the edge that accepts the K-th beat, so it is visible in the following cycle.
REQ-026 start is ignored outside IDLE; in_valid is ignored outside ACC.
REQ-027 Beats with gaps (in_valid low) only stall the count; no timeout.
REQ-028 The accumulator never wraps for K<=256 with any N-bit operands; saturation is applied only at the output.

Reset
REQ-029 With rst=0 at an edge: FSM=IDLE, acc=0, cnt=0, y=0, out_valid=0, in_ready=0, busy=0.
REQ-030 Reset during ACC or OUT aborts the operation; the partial result is discarded and never presented.

Structure
REQ-031 The shared fixed-point package holds N, Q, the saturation limits SAT_MAX=0x7FFF and SAT_MIN=0x8000, and the FSM state encoding.
REQ-032 Shift-and-saturate is one combinational sub-module, fx_shift_saturate (in ACC_W, out N); the existing truncating 16-bit multiplier is not reused because full-precision products are required.

Verification
REQ-033 K=4, bias=0, four beats x=0x1000, w=0x0800 -> y=0x2000, out_valid in the cycle after the 4th accept.
REQ-034 K=4, bias=0x0800, beats x=0x7000, w=0x7000 -> y=0x7FFF; with x=0x9000, w=0x7000 -> y=0x8000.
REQ-035 K=4, bias=0, beats x=0xFFFF, w=0x0001 -> y=0xFFFF (sum -4 in Q24, floor); with x=0x0001, w=0x0001 -> y=0x0000.
REQ-036 out_ready held 0 for 5 cycles -> y and out_valid stable, in_ready=0, a start pulse is ignored; out_ready=1 -> IDLE the next cycle.
REQ-037 rst=0 after 2 of 4 beats, then a new start with bias=0 and 4 beats of 0x1000*0x1000 -> y=0x4000, with no leakage from the aborted run.
REQ-038 Random in_valid gaps with K=8 and random operands -> y matches a reference model of floor-and-saturate over the exact sum.
